// File: rtl/clk_div_sel_ctrl.sv
// Sequencer for a bank of power-of-2 clock dividers: parks the running divider,
// starts the selected one, and only then re-enables the downstream clock mux.
module clk_div_sel_ctrl #(
  parameter int N_DIV   = 4,
  parameter int MAX_DIV = 64,
  parameter int WARMUP  = 4,
  parameter int RST_IDX = 0
) (
  input  logic                       refclk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(N_DIV)-1:0]   req_idx,
  input  logic                       req_off,
  input  logic                       err_clr,
  output logic [N_DIV-1:0]           divclk_sel,
  input  logic [N_DIV-1:0]           div_msb,
  output logic [$clog2(N_DIV)-1:0]   mux_sel,
  output logic                       mux_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int IW = $clog2(N_DIV);
  localparam int CW = $clog2(2*MAX_DIV) + 1;
  localparam logic [CW-1:0]    DRAIN_LAST = CW'(2*MAX_DIV - 1);
  localparam logic [CW-1:0]    WARM_LAST  = CW'(WARMUP - 1);
  localparam logic [N_DIV-1:0] SEL_RST    = N_DIV'(1) << RST_IDX;

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] WARM  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] cur;
  logic          cur_on;
  logic [IW-1:0] tgt;
  logic          tgt_off;
  logic          idx_bad;

  // Out-of-range indices only exist when N_DIV is not a power of two.
  if (N_DIV == (1 << IW)) begin : g_pow2
    assign idx_bad = 1'b0;
  end else begin : g_np2
    assign idx_bad = ({{(32-IW){1'b0}}, req_idx} >= 32'(N_DIV));
  end

  function automatic logic [N_DIV-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign busy = ~req_ready;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= INIT;
      cnt        <= '0;
      cur        <= IW'(RST_IDX);
      cur_on     <= 1'b1;
      tgt        <= '0;
      tgt_off    <= 1'b0;
      divclk_sel <= SEL_RST;
      mux_sel    <= IW'(RST_IDX);
      mux_en     <= 1'b0;
      req_ready  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_clr) err <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == DRAIN_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            mux_en    <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            if (!req_off && idx_bad) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else if ((!req_off && cur_on && req_idx == cur) || (req_off && !cur_on)) begin
              done <= 1'b1;
            end else if (!cur_on) begin
              // Nothing is running, so there is nothing to drain.
              cur        <= req_idx;
              divclk_sel <= onehot(req_idx);
              mux_sel    <= req_idx;
              state      <= WARM;
              cnt        <= '0;
              req_ready  <= 1'b0;
            end else begin
              divclk_sel <= '0;
              mux_en     <= 1'b0;
              tgt        <= req_idx;
              tgt_off    <= req_off;
              state      <= DRAIN;
              cnt        <= '0;
              req_ready  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            // A high MSB after the full window means the divider never parked.
            if (div_msb[cur]) err <= 1'b1;
            cnt <= '0;
            if (tgt_off) begin
              cur_on    <= 1'b0;
              done      <= 1'b1;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              cur        <= tgt;
              divclk_sel <= onehot(tgt);
              mux_sel    <= tgt;
              state      <= WARM;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WARM: begin
          if (cnt == WARM_LAST) begin
            mux_en    <= 1'b1;
            done      <= 1'b1;
            cur_on    <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: doc/clk_div_sel_ctrl.md
# clk_div_sel_ctrl

Sequencing controller for a bank of power-of-2 clock dividers sharing one reference clock. Exactly one divider runs at a time; the others are parked. On request, the block:
- stops the running divider and waits out its worst-case park time,
- starts the newly selected divider and waits out a warm-up period,
- only then re-enables the downstream output clock mux.

It sits between a CSR/power-management requester and the divider bank plus the downstream clock mux. It drives each divider's run-select and observes each divider's count MSB.

## Interface
- N_DIV, 4: number of dividers; must be ≥ 2.
- MAX_DIV, 64: largest divide ratio in the bank; power of 2, ≥ 2.
- WARMUP, 4: refclk cycles between starting a divider and enabling the mux; must be ≥ 1.
- RST_IDX, 0: divider running out of reset; must be < N_DIV.
- refclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  request accept; handshake completes when req_valid && req_ready.
- req_idx  in  $clog2(N_DIV)  divider to run; ignored when req_off=1.
- req_off  in  1  1 = stop all dividers.
- err_clr  in  1  clears err.
- divclk_sel  out  N_DIV  per-divider run-select; at most one bit set.
- div_msb  in  N_DIV  per-divider count MSB feedback.
- mux_sel  out  $clog2(N_DIV)  downstream clock mux select.
- mux_en  out  1  downstream clock mux enable.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse per accepted request.
- err  out  1  sticky error flag.

## Operation
- States: INIT, IDLE, DRAIN, WARM.
- Internal state: active index `cur` and flag `cur_on`.
- Reset values:
  - divclk_sel = 1<<RST_IDX; mux_sel = RST_IDX; cur = RST_IDX; cur_on = 1.
  - mux_en = 0, req_ready = 0, busy = 1, done = 0, err = 0.
  - State = INIT; drain counter = 0.
- INIT: count 2*MAX_DIV cycles so non-selected dividers park and the selected one settles. Then go to IDLE with mux_en = 1.
- IDLE: req_ready = 1 and busy = 0. On accept, one of five cases applies:
  - **Invalid** (req_off = 0 and req_idx ≥ N_DIV): set err, pulse done, no other change, stay in IDLE.
  - **No-op** (req_off = 0, cur_on = 1, req_idx == cur), or (req_off = 1, cur_on = 0): pulse done, no other change, stay in IDLE.
  - **Cold start** (cur_on = 0): set divclk_sel[req_idx] and mux_sel = req_idx; go to WARM.
  - **Switch**: clear divclk_sel[cur] and mux_en; latch the target index; go to DRAIN.
  - **Stop**: same as Switch, with the target recorded as "none".
- DRAIN: count exactly 2*MAX_DIV cycles, which covers the divider's worst-case 1.5×DIV run-out. In the last DRAIN cycle, sample div_msb[cur]; if it is 1, set err (park failure) and continue anyway. On exit:
  - Stop: cur_on = 0; pulse done; go to IDLE with mux_en = 0.
  - Switch: cur = target; set divclk_sel[target]; mux_sel = target; go to WARM.
- WARM: count WARMUP cycles, then set mux_en = 1, pulse done, set cur_on = 1, and go to IDLE.
- Invariants:
  - mux_sel changes only while mux_en = 0.
  - divclk_sel is never multi-hot.
  - A divider is never restarted within the same request in which it was stopped.
- err is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, the set wins.
- Counter width is $clog2(2*MAX_DIV)+1. The counter resets to 0 on each state entry.

## Timing
- Let T be the accept cycle. All registered outputs update from T+1.
- Invalid/no-op: done high at T+1; req_ready stays high.
- Cold start:
  - divclk_sel and mux_sel update at T+1.
  - mux_en = 1 and done = 1 at T+1+WARMUP.
- Switch:
  - divclk_sel[cur] = 0 and mux_en = 0 at T+1.
  - div_msb sampled at T+2*MAX_DIV.
  - New divclk_sel bit and mux_sel at T+2*MAX_DIV+1.
  - mux_en = 1 and done = 1 at T+2*MAX_DIV+1+WARMUP.
- Stop: done at T+2*MAX_DIV+1; mux_en remains 0.
- Handshake signals:
  - req_ready is 0 from T+1 until the cycle done is high; it is 1 in that done cycle.
  - busy = ~req_ready.
- INIT: mux_en and req_ready rise 2*MAX_DIV+1 cycles after the last rst-high cycle.
- rst asserted mid-sequence: on the next edge, all outputs take their reset values; no done is issued for the aborted request.

## Test plan
All scenarios use N_DIV=4, MAX_DIV=8, WARMUP=4, RST_IDX=0.
- **Reset:** hold rst 3 cycles → divclk_sel=4'b0001, mux_sel=0, mux_en=0, req_ready=0; mux_en=1 and req_ready=1 exactly 17 cycles after rst falls.
- **Switch 0→2 with real dividers (DIV=8) attached:** accept at T → divclk_sel=0 at T+1; divclk_sel=4'b0100 and mux_sel=2 at T+17; mux_en=1 and done=1 at T+21; err=0.
- **Stop then cold start:** req_off=1 → done at T+17, divclk_sel=0, mux_en stays 0. Then req_idx=3 at U → divclk_sel=4'b1000 at U+1; done and mux_en at U+5.
- **Invalid and no-op requests:**
  - Request idx 0 while running 0 → done at T+1, outputs unchanged, err=0.
  - Force div_msb[0]=1 through the drain window → err=1 after the switch.
  - err_clr → err=0.
- **Reset mid-DRAIN:** assert rst at T+5 → reset values on the next edge, no done pulse, INIT restarts.
- **Back-to-back requests:** hold req_valid high continuously → req_ready=0 during each sequence; exactly one done per accept; divclk_sel never multi-hot; mux_sel never changes while mux_en=1 (assertions).
